stream_qos_arbiter_aging: RTL

Packet-granular QoS arbiter that merges `STREAM_COUNT` valid/ready input streams onto one registered output stream. The highest `s_qos_i` wins, ties are broken round-robin, and an optional aging mechanism guarantees that low-QoS streams cannot starve. It sits in front of the shared output datapath and locks a grant for a whole packet, from the first beat to the `s_last_i` beat.

---
 rtl/stream_qos_arbiter_aging.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/stream_qos_arbiter_aging.sv
// rtl/stream_qos_arbiter_aging.sv - packet-granular QoS arbiter with round-robin tie-break and optional aging
//
// Merges STREAM_COUNT valid/ready input streams onto one registered output
// stream. A grant is taken in IDLE and held for a whole packet (first beat to
// the s_last_i beat). Highest s_qos_i wins; ties resolve round-robin from
// rr_ptr. With STREAM_ARB_QOS_AGING_EN defined, per-stream age counters
// promote streams that keep losing to "urgent", which beats any non-urgent one.
//
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   s_data_i/s_qos_i    per-stream data and QoS (QoS sampled at arbitration)
//   s_last_i/s_valid_i  per-stream end-of-packet and valid
//   s_ready_o           per-stream ready, combinational, one-hot or zero
//   m_data_o/m_last_o   registered output beat
//   m_qos_o/m_id_o      QoS latched at grant and granted stream index
//   m_valid_o/m_ready_i output handshake
//
// Optional feature macro: STREAM_ARB_QOS_AGING_EN

module stream_qos_arbiter_aging #(
    parameter int T_DATA_WIDTH = 8,
    parameter int T_QOS__WIDTH = 4,
    parameter int STREAM_COUNT = 2,
    parameter int T_ID___WIDTH = $clog2(STREAM_COUNT),
    parameter int AGE_WIDTH    = 4,
    parameter int AGE_LIMIT    = 15
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [STREAM_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i,
    input  logic [STREAM_COUNT-1:0][T_QOS__WIDTH-1:0] s_qos_i,
    input  logic [STREAM_COUNT-1:0]                  s_last_i,
    input  logic [STREAM_COUNT-1:0]                  s_valid_i,
    output logic [STREAM_COUNT-1:0]                  s_ready_o,
    output logic [T_DATA_WIDTH-1:0]                  m_data_o,
    output logic [T_QOS__WIDTH-1:0]                  m_qos_o,
    output logic [T_ID___WIDTH-1:0]                  m_id_o,
    output logic                                     m_last_o,
    output logic                                     m_valid_o,
    input  logic                                     m_ready_i
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [T_ID___WIDTH-1:0] LAST_ID = T_ID___WIDTH'(STREAM_COUNT - 1);

    state_t                  state_q, state_d;
    logic [T_ID___WIDTH-1:0] grant_q, grant_d;
    logic [T_ID___WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [T_QOS__WIDTH-1:0] pkt_qos_q, pkt_qos_d;

    logic [T_DATA_WIDTH-1:0] m_data_q, m_data_d;
    logic [T_QOS__WIDTH-1:0] m_qos_q, m_qos_d;
    logic [T_ID___WIDTH-1:0] m_id_q, m_id_d;
    logic                    m_last_q, m_last_d;
    logic                    m_valid_q, m_valid_d;

    logic [STREAM_COUNT-1:0] urgent;
    logic [T_ID___WIDTH-1:0] winner;
    logic                    start_grant;
    logic                    beat_accept;

    // ------------------------------------------------------------------
    // Aging
    // ------------------------------------------------------------------
`ifdef STREAM_ARB_QOS_AGING_EN
    localparam logic [AGE_WIDTH-1:0] AGE_LIMIT_V = AGE_WIDTH'(AGE_LIMIT);

    logic [STREAM_COUNT-1:0][AGE_WIDTH-1:0] age_q, age_d;

    for (genvar gi = 0; gi < STREAM_COUNT; gi++) begin : g_urgent
        assign urgent[gi] = (age_q[gi] >= AGE_LIMIT_V);
    end

    // Ages only move on an IDLE->GRANT event: the winner restarts from 0,
    // every other waiting stream gains one (saturating), idle streams keep theirs.
    always_comb begin
        age_d = age_q;
        if (start_grant) begin
            for (int i = 0; i < STREAM_COUNT; i++) begin
                if (T_ID___WIDTH'(i) == winner) begin
                    age_d[i] = '0;
                end else if (s_valid_i[i] && (age_q[i] != '1)) begin
                    age_d[i] = age_q[i] + AGE_WIDTH'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            age_q <= '0;
        end else begin
            age_q <= age_d;
        end
    end
`else
    assign urgent = '0;

    // Age parameters have no function without the aging counters.
    logic [31:0] unused_age_cfg;
    assign unused_age_cfg = 32'(AGE_WIDTH) ^ 32'(AGE_LIMIT);
`endif

    // ------------------------------------------------------------------
    // Arbitration: search upward from rr_ptr so that the first candidate
    // with the strictly largest {urgent, qos} key wins; equal keys found
    // later in the search never replace it, which gives the round-robin tie-break.
    // ------------------------------------------------------------------
    always_comb begin
        int                    idx;
        logic                  found;
        logic [T_QOS__WIDTH:0] best_key;
        logic [T_QOS__WIDTH:0] cand_key;
        winner   = rr_ptr_q;
        found    = 1'b0;
        best_key = '0;
        idx      = 0;
        cand_key = '0;
        for (int k = 0; k < STREAM_COUNT; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= STREAM_COUNT) begin
                idx = idx - STREAM_COUNT;
            end
            cand_key = {urgent[idx], s_qos_i[idx]};
            if (s_valid_i[idx] && (!found || (cand_key > best_key))) begin
                found    = 1'b1;
                best_key = cand_key;
                winner   = T_ID___WIDTH'(idx);
            end
        end
    end

    // ------------------------------------------------------------------
    // FSM next state, handshake and output register next values
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_qos_d   = pkt_qos_q;
        m_data_d    = m_data_q;
        m_qos_d     = m_qos_q;
        m_id_d      = m_id_q;
        m_last_d    = m_last_q;
        m_valid_d   = m_valid_q;
        s_ready_o   = '0;
        start_grant = 1'b0;
        beat_accept = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|s_valid_i) begin
                    start_grant = 1'b1;
                    state_d     = ST_GRANT;
                    grant_d     = winner;
                    pkt_qos_d   = s_qos_i[winner];
                    rr_ptr_d    = (winner == LAST_ID) ? '0 : winner + T_ID___WIDTH'(1);
                end
            end
            ST_GRANT: begin
                // Ready only when the output register is free or draining this cycle.
                s_ready_o[grant_q] = ~m_valid_q | m_ready_i;
                beat_accept        = s_valid_i[grant_q] & s_ready_o[grant_q];
                if (beat_accept && s_last_i[grant_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (beat_accept) begin
            m_data_d  = s_data_i[grant_q];
            m_last_d  = s_last_i[grant_q];
            m_id_d    = grant_q;
            m_qos_d   = pkt_qos_q;
            m_valid_d = 1'b1;
        end else if (m_ready_i) begin
            m_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= '0;
            rr_ptr_q  <= '0;
            pkt_qos_q <= '0;
            m_data_q  <= '0;
            m_qos_q   <= '0;
            m_id_q    <= '0;
            m_last_q  <= 1'b0;
            m_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            pkt_qos_q <= pkt_qos_d;
            m_data_q  <= m_data_d;
            m_qos_q   <= m_qos_d;
            m_id_q    <= m_id_d;
            m_last_q  <= m_last_d;
            m_valid_q <= m_valid_d;
        end
    end

    assign m_data_o  = m_data_q;
    assign m_qos_o   = m_qos_q;
    assign m_id_o    = m_id_q;
    assign m_last_o  = m_last_q;
    assign m_valid_o = m_valid_q;

endmodule
